hevc_subpel_interp: RTL and testbench
=====================================

# hevc_subpel_interp

Parametrised HEVC luma fractional-sample interpolator. It produces one selected quarter-pel position (frac_x, frac_y ∈ 0..3) for a W×H prediction block using the separable 8-tap filters. Source rows of W+7 reference pixels stream in over a valid/ready handshake and filtered rows of W pixels stream out. It succeeds the fixed-size A/B/C engine, adding runtime position select, bit-depth and block-size parameters, and backpressure on both sides.

## Interface
- W, 8: block width in samples (4..64)
- H, 8: block height in rows (4..64)
- BD, 8: sample bit depth (8..10)
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches frac_x/frac_y and begins a block; ignored while busy
- frac_x  in  2  horizontal quarter-pel phase
- frac_y  in  2  vertical quarter-pel phase
- busy  out  1  high from the cycle after an accepted start until done
- row_idx  out  8  index (0..H+6) of the source row requested next; drives the row store address
- in_row  in  (W+7)*BD  source row; pixel j in bits [j*BD +: BD], j=0 is x-3
- in_valid  in  1  in_row valid
- in_ready  out  1  row accepted when in_valid && in_ready
- out_row  out  W*BD  filtered row; sample j in bits [j*BD +: BD]
- out_valid  out  1  out_row valid; held stable until out_ready
- out_ready  in  1  downstream accept
- done  out  1  one-cycle pulse on the cycle the last (row H-1) output handshake completes

## Operation
- Coefficient sets by phase: 0 = {0,0,0,64,0,0,0,0}; 1 = {-1,4,-10,58,17,-5,1,0}; 2 = {-1,4,-11,40,40,-11,4,-1}; 3 = {0,1,-5,17,58,-10,4,-1}. Tap k applies to offset k-3.
- Phase 0 uses the unit-weight set, so all phases share one datapath and full-pel output is exact.
- Horizontal: for each sample j, sum_h = Σ c_x[k]·p[j+k] (signed, BD+8 bits); I = sum_h >>> (BD-8), stored as 16-bit signed.
- Line buffer: 8 entries of W×16-bit, shifted on every accepted input row.
- Vertical: sum_v = Σ c_y[k]·I[row+k] (signed, 24 bits); out = clip((sum_v + 2^(19-BD)) >>> (20-BD), 0, 2^BD-1).
- A block consumes exactly H+7 source rows. Output row r is formed once source row r+7 has been accepted.
- FSM states:
  - IDLE: start → FILL, row_idx=0
  - FILL: rows 0..6 accepted, no output → RUN after row 6
  - RUN: rows 7..H+6, each yields one output → DRAIN after row H+6
  - DRAIN: waits for the final output handshake, pulses done → IDLE
- pend flag: set when a full window has been shifted in but not yet moved to the output register; cleared on move.
- in_ready = (FILL or RUN) && (!pend || !out_valid || out_ready).

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_row=0, done=0, row_idx=0, state=IDLE, pend=0, line buffer=0.
- An input accepted at edge t (RUN) updates the line buffer at t. The output register loads at edge t+1 if the slot is free, so out_valid is seen after t+1. Latency is 2 edges.
- With out_ready held high, throughput is 1 row/cycle: H+7 accept cycles plus 1.
- Backpressure: out_valid && !out_ready holds out_row and, once pend is set, drops in_ready. No row is lost or duplicated.
- row_idx increments on each accepted row and saturates at H+6 until IDLE.
- start while busy is ignored. start in the same cycle as done is accepted.
- rst mid-block returns everything to the reset values on the next edge. Partial rows are discarded and no done is pulsed.
- frac_x/frac_y are sampled only on an accepted start; changes mid-block have no effect.

## Structure
- Package hevc_interp_pkg holds:
  - coefficient table function coef(phase, tap) returning signed 8-bit values
  - state enum
  - widths IW=16 and VW=24
- Sub-module fir8_tap (8 signed inputs, phase select, registered=0, signed sum out) is instantiated W times for the horizontal pass and W times for the vertical pass.
- Top level holds the FSM, row counter, line buffer, pend/output register, rounding and clip.

## Test plan
- frac=(0,0), BD=8, random rows → out_row equals source pixels 3..W+2 of rows 3..H+2 exactly; done after H outputs.
- Constant 100 image, all 16 phase pairs → every sample 100.
- Horizontal ramp p=10·x, frac=(2,0) → sample j equals 10·(j+0.5)+... i.e. exact midpoint 10x+5; step 0/255 at centre gives 128.
- out_ready toggled 1-of-3 cycles, random data → output sequence matches the golden model; in_ready low while stalled with pend set.
- rst asserted after 10 accepted rows → all outputs at reset values next cycle; a new start completes correctly.
- BD=10, W=16, H=4, frac=(1,3), random → bit-exact against the golden model; 11 rows consumed, 4 emitted.

Source files
------------

// File: rtl/hevc_interp_pkg.sv
// Shared types, widths and the HEVC luma 8-tap coefficient table for the
// sub-pel interpolator.
package hevc_interp_pkg;

  localparam int IW = 16;
  localparam int VW = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Phase 0 is the unit-weight set, so full-pel output shares the filter path
  localparam logic signed [7:0] COEF_TBL [4][8] = '{
    '{ 8'sd0,  8'sd0,  8'sd0,   8'sd64,  8'sd0,   8'sd0,   8'sd0,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,   8'sd1,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11,  8'sd4, -8'sd1},
    '{ 8'sd0,  8'sd1, -8'sd5,   8'sd17,  8'sd58, -8'sd10,  8'sd4, -8'sd1}
  };

  function automatic logic signed [7:0] coef(input logic [1:0] phase, input logic [2:0] tap);
    return COEF_TBL[phase][tap];
  endfunction

endpackage

// File: rtl/hevc_subpel_interp_if.sv
// Control, row-in and row-out handshake bundle of the sub-pel interpolator.
interface hevc_subpel_interp_if #(
  parameter int W  = 8,
  parameter int BD = 8
);
  logic                    start;
  logic [1:0]              frac_x;
  logic [1:0]              frac_y;
  logic                    busy;
  logic [7:0]              row_idx;
  logic [(W+7)*BD-1:0]     in_row;
  logic                    in_valid;
  logic                    in_ready;
  logic [W*BD-1:0]         out_row;
  logic                    out_valid;
  logic                    out_ready;
  logic                    done;

  modport master (
    output start, frac_x, frac_y, in_row, in_valid, out_ready,
    input  busy, row_idx, in_ready, out_row, out_valid, done
  );

  modport slave (
    input  start, frac_x, frac_y, in_row, in_valid, out_ready,
    output busy, row_idx, in_ready, out_row, out_valid, done
  );
endinterface

// File: rtl/fir8_tap.sv
// Combinational 8-tap signed FIR: sum of taps[k] * coef(phase, k), tap k
// weighting sample offset k-3.
module fir8_tap
  import hevc_interp_pkg::*;
#(
  parameter int IN_W  = IW,
  parameter int OUT_W = VW
) (
  input  logic [1:0]              phase,
  input  logic [8*IN_W-1:0]       taps,
  output logic signed [OUT_W-1:0] sum
);

  logic signed [OUT_W-1:0] xs [8];
  logic signed [OUT_W-1:0] cs [8];

  for (genvar k = 0; k < 8; k++) begin : g_tap
    logic signed [7:0] c;
    assign c     = coef(phase, 3'(k));
    assign xs[k] = {{(OUT_W-IN_W){taps[k*IN_W+IN_W-1]}}, taps[k*IN_W +: IN_W]};
    assign cs[k] = {{(OUT_W-8){c[7]}}, c};
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++) sum = sum + xs[k] * cs[k];
  end

endmodule

// File: rtl/hevc_subpel_interp.sv
// HEVC luma quarter-pel interpolator: horizontal 8-tap per source row into an
// 8-row intermediate line buffer, vertical 8-tap per window, round and clip.
//
// state   | meaning
// IDLE    | waiting for start
// FILL    | accepting source rows 0..6, no output yet
// RUN     | accepting rows 7..H+6, each completes one output window
// DRAIN   | all rows in, waiting for the last output handshake
module hevc_subpel_interp
  import hevc_interp_pkg::*;
#(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int BD = 8
) (
  input  logic             clk,
  input  logic             rst,
  hevc_subpel_interp_if.slave bus
);

  localparam logic [7:0] FILL_LAST = 8'd6;
  localparam logic [7:0] LAST_ROW  = 8'(H + 6);
  localparam logic signed [VW-1:0] RND    = VW'(1 << (19 - BD));
  localparam logic signed [VW-1:0] PX_MAX = VW'((1 << BD) - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       fx_q;
  logic [1:0]       fy_q;
  logic [7:0]       row_idx_q;
  logic             pend;
  logic             out_valid_q;
  logic [W*BD-1:0]  out_row_q;
  logic [W*IW-1:0]  lb [8];
  logic [W*IW-1:0]  h_row;
  logic [W*BD-1:0]  v_row;
  logic             in_acc;
  logic             start_acc;
  logic             move;
  logic             busy_c;
  logic             in_ready_c;
  logic             done_c;

  function automatic logic [BD-1:0] clip_px(input logic signed [VW-1:0] s);
    logic signed [VW-1:0] r;
    r = (s + RND) >>> (20 - BD);
    if (r < 0) return '0;
    if (r > PX_MAX) return '1;
    return r[BD-1:0];
  endfunction

  assign in_acc    = bus.in_valid && in_ready_c;
  assign start_acc = bus.start && ((state == S_IDLE) || done_c);
  assign move      = pend && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_FILL;
      S_FILL:  if (in_acc && (row_idx_q == FILL_LAST)) state_nxt = S_RUN;
      S_RUN:   if (in_acc && (row_idx_q == LAST_ROW)) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (start_acc)   state_nxt = S_FILL;
        else if (done_c) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new row is only taken if the window it completes has somewhere to go
  always_comb begin
    busy_c     = (state != S_IDLE);
    in_ready_c = ((state == S_FILL) || (state == S_RUN)) &&
                 (!pend || !out_valid_q || bus.out_ready);
    done_c     = (state == S_DRAIN) && !pend && out_valid_q && bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fx_q        <= '0;
      fy_q        <= '0;
      row_idx_q   <= '0;
      pend        <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      for (int i = 0; i < 8; i++) lb[i] <= '0;
    end else begin
      if (start_acc) begin
        fx_q <= bus.frac_x;
        fy_q <= bus.frac_y;
      end
      if (start_acc || done_c)
        row_idx_q <= '0;
      else if (in_acc && (row_idx_q != LAST_ROW))
        row_idx_q <= row_idx_q + 8'd1;
      if (in_acc) begin
        for (int i = 0; i < 7; i++) lb[i] <= lb[i+1];
        lb[7] <= h_row;
      end
      if (in_acc && (state == S_RUN)) pend <= 1'b1;
      else if (move)                  pend <= 1'b0;
      if (move) begin
        out_row_q   <= v_row;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // lb[k] holds source row (r+k) of the window for output row r
  for (genvar j = 0; j < W; j++) begin : g_col
    logic [8*IW-1:0]       h_taps;
    logic [8*IW-1:0]       v_taps;
    logic signed [VW-1:0]  h_sum;
    logic signed [VW-1:0]  v_sum;

    for (genvar k = 0; k < 8; k++) begin : g_k
      assign h_taps[k*IW +: IW] = {{(IW-BD){1'b0}}, bus.in_row[(j+k)*BD +: BD]};
      assign v_taps[k*IW +: IW] = lb[k][j*IW +: IW];
    end

    fir8_tap #(.IN_W(IW), .OUT_W(VW)) u_fir_h (
      .phase (fx_q),
      .taps  (h_taps),
      .sum   (h_sum)
    );

    fir8_tap #(.IN_W(IW), .OUT_W(VW)) u_fir_v (
      .phase (fy_q),
      .taps  (v_taps),
      .sum   (v_sum)
    );

    assign h_row[j*IW +: IW] = IW'(h_sum >>> (BD - 8));
    assign v_row[j*BD +: BD] = clip_px(v_sum);
  end

  assign bus.busy      = busy_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.done      = done_c;
  assign bus.row_idx   = row_idx_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_hevc_subpel_interp.sv
// Directed bench for hevc_subpel_interp: two configurations, a reference
// interpolation model feeding a scoreboard, and output-side backpressure.
module tb_hevc_subpel_interp;

  localparam int WA = 8,  HA = 8, BDA = 8;
  localparam int WB = 16, HB = 4, BDB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hevc_subpel_interp_if #(.W(WA), .BD(BDA)) ia ();
  hevc_subpel_interp_if #(.W(WB), .BD(BDB)) ib ();

  hevc_subpel_interp #(.W(WA), .H(HA), .BD(BDA)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  hevc_subpel_interp #(.W(WB), .H(HB), .BD(BDB)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  localparam int CF [4][8] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  int errors = 0;
  int checks = 0;
  int img [0:70][0:70];
  logic [255:0] sb_a[$];
  logic [255:0] sb_b[$];
  int cyc = 0;
  int rdy_mode = 0;
  int start_cyc = 0;
  int done_a = 0, done_b = 0, done_cyc_a = 0, outs_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] v, input int j, input int bd, input int val);
    for (int b = 0; b < bd; b++) v[j*bd+b] = val[b];
    return v;
  endfunction

  function automatic int hsum(input int row, input int j, input int fx, input int bd);
    int s = 0;
    for (int k = 0; k < 8; k++) s += CF[fx][k] * img[row][j+k];
    return s >>> (bd - 8);
  endfunction

  function automatic int gold(input int r, input int j, input int fx, input int fy, input int bd);
    int v = 0;
    int o;
    for (int k = 0; k < 8; k++) v += CF[fy][k] * hsum(r + k, j, fx, bd);
    o = (v + (1 << (19 - bd))) >>> (20 - bd);
    if (o < 0) o = 0;
    if (o > (1 << bd) - 1) o = (1 << bd) - 1;
    return o;
  endfunction

  function automatic logic [255:0] gold_row(input int r, input int w, input int fx, input int fy, input int bd);
    logic [255:0] v = '0;
    for (int j = 0; j < w; j++) v = put(v, j, bd, gold(r, j, fx, fy, bd));
    return v;
  endfunction

  function automatic logic [255:0] pack_in(input int r, input int w, input int bd);
    logic [255:0] v = '0;
    for (int j = 0; j < w + 7; j++) v = put(v, j, bd, img[r][j]);
    return v;
  endfunction

  task automatic push_model(input int sel, input int fx, input int fy);
    if (sel == 0) for (int r = 0; r < HA; r++) sb_a.push_back(gold_row(r, WA, fx, fy, BDA));
    else          for (int r = 0; r < HB; r++) sb_b.push_back(gold_row(r, WB, fx, fy, BDB));
  endtask

  task automatic rand_img(input int maxv);
    for (int r = 0; r < 71; r++)
      for (int c = 0; c < 71; c++) img[r][c] = int'($urandom_range(maxv));
  endtask

  task automatic do_start(input int sel, input int fx, input int fy);
    if (sel == 0) begin ia.start = 1'b1; ia.frac_x = fx[1:0]; ia.frac_y = fy[1:0]; end
    else          begin ib.start = 1'b1; ib.frac_x = fx[1:0]; ib.frac_y = fy[1:0]; end
    @(posedge clk); #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic feed(input int sel, input int first, input int last, input int max_cyc, output int n);
    int r = first;
    int c = 0;
    logic hs;
    while (r <= last && c < max_cyc) begin
      if (sel == 0) begin
        ia.in_row = pack_in(r, WA, BDA) >> 0;
        ia.in_valid = 1'b1;
      end else begin
        ib.in_row = pack_in(r, WB, BDB) >> 0;
        ib.in_valid = 1'b1;
      end
      @(negedge clk);
      hs = (sel == 0) ? ia.in_ready : ib.in_ready;
      @(posedge clk); #1;
      if (hs) r++;
      c++;
    end
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    n = r - first;
  endtask

  task automatic wait_done(input int sel, input int max_cyc);
    int prev = (sel == 0) ? done_a : done_b;
    int c = 0;
    while (((sel == 0) ? done_a : done_b) == prev && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk(sel == 0 ? "a_done_count" : "b_done_count", (sel == 0) ? done_a : done_b, prev + 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_a();
    chk("a_rst_busy", ia.busy, 0);
    chk("a_rst_in_ready", ia.in_ready, 0);
    chk("a_rst_out_valid", ia.out_valid, 0);
    chk("a_rst_out_row", ia.out_row, 0);
    chk("a_rst_done", ia.done, 0);
    chk("a_rst_row_idx", ia.row_idx, 0);
  endtask

  always @(negedge clk) begin
    logic [255:0] e;
    if (!rst) begin
      if (ia.out_valid && ia.out_ready) begin
        if (sb_a.size() > 0) e = sb_a.pop_front(); else e = '1;
        chk("a_out_row", ia.out_row, e);
        chk("a_done_at_last", ia.done, sb_a.size() == 0);
        if (ia.done) begin done_a++; done_cyc_a = cyc; end
      end else if (ia.done) begin
        chk("a_done_spurious", ia.done, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [255:0] e;
    if (!rst) begin
      if (ib.out_valid && ib.out_ready) begin
        if (sb_b.size() > 0) e = sb_b.pop_front(); else e = '1;
        outs_b++;
        chk("b_out_row", ib.out_row, e);
        chk("b_done_at_last", ib.done, sb_b.size() == 0);
        if (ib.done) done_b++;
      end else if (ib.done) begin
        chk("b_done_spurious", ib.done, 0);
      end
    end
  end

  initial begin
    int n;
    logic [255:0] e;
    ia.start = 0; ia.frac_x = 0; ia.frac_y = 0; ia.in_row = '0; ia.in_valid = 0; ia.out_ready = 1;
    ib.start = 0; ib.frac_x = 0; ib.frac_y = 0; ib.in_row = '0; ib.in_valid = 0; ib.out_ready = 1;

    fork
      forever begin
        @(posedge clk); #1;
        ia.out_ready = (rdy_mode == 0) || (rdy_mode == 1 && cyc % 3 == 0);
        ib.out_ready = (rdy_mode == 0) || (rdy_mode == 1 && cyc % 3 == 0);
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_a();
    chk("b_rst_busy", ib.busy, 0);
    chk("b_rst_out_valid", ib.out_valid, 0);
    chk("b_rst_out_row", ib.out_row, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-pel: output equals source pixels shifted by 3 in both directions
    rand_img(255);
    for (int r = 0; r < HA; r++) begin
      e = '0;
      for (int j = 0; j < WA; j++) e = put(e, j, BDA, img[r+3][j+3]);
      sb_a.push_back(e);
    end
    do_start(0, 0, 0);
    chk("a_fp_busy", ia.busy, 1);
    feed(0, 0, HA + 6, 200, n);
    chk("a_fp_rows", n, HA + 7);
    chk("a_fp_row_idx_sat", ia.row_idx, HA + 6);
    chk("a_fp_in_ready_drain", ia.in_ready, 0);
    wait_done(0, 100);
    chk("a_fp_latency", done_cyc_a - start_cyc, HA + 8);
    chk("a_fp_idle_busy", ia.busy, 0);
    chk("a_fp_idle_row_idx", ia.row_idx, 0);

    // Constant image through every phase pair
    for (int r = 0; r < 71; r++) for (int c = 0; c < 71; c++) img[r][c] = 100;
    for (int fx = 0; fx < 4; fx++) begin
      for (int fy = 0; fy < 4; fy++) begin
        e = '0;
        for (int j = 0; j < WA; j++) e = put(e, j, BDA, 100);
        for (int r = 0; r < HA; r++) sb_a.push_back(e);
        do_start(0, fx, fy);
        feed(0, 0, HA + 6, 200, n);
        wait_done(0, 100);
      end
    end

    // Horizontal ramp at half-pel lands exactly on the midpoints
    for (int r = 0; r < 71; r++) for (int c = 0; c < 71; c++) img[r][c] = 10 * c;
    e = '0;
    for (int j = 0; j < WA; j++) e = put(e, j, BDA, 10 * (j + 3) + 5);
    for (int r = 0; r < HA; r++) sb_a.push_back(e);
    do_start(0, 2, 0);
    feed(0, 0, HA + 6, 200, n);
    wait_done(0, 100);

    // 0/255 step between columns 7 and 8: the sample centred on it is 128
    for (int r = 0; r < 71; r++) for (int c = 0; c < 71; c++) img[r][c] = (c < 8) ? 0 : 255;
    for (int r = 0; r < HA; r++) begin
      e = gold_row(r, WA, 2, 0, BDA);
      e[39:32] = 8'd128;
      sb_a.push_back(e);
    end
    do_start(0, 2, 0);
    feed(0, 0, HA + 6, 200, n);
    wait_done(0, 100);

    // Output stall: two windows fit (out register + pend), then in_ready drops
    rand_img(255);
    begin
      int fx = int'($urandom_range(3));
      int fy = int'($urandom_range(3));
      push_model(0, fx, fy);
      rdy_mode = 2;
      do_start(0, fx, fy);
      feed(0, 0, HA + 6, 30, n);
      chk("a_stall_rows", n, 9);
      chk("a_stall_in_ready", ia.in_ready, 0);
      chk("a_stall_out_valid", ia.out_valid, 1);
      chk("a_stall_out_row", ia.out_row, sb_a[0]);
      ia.frac_x = 2'(fx + 1); ia.frac_y = 2'(fy + 2); ia.start = 1'b1;
      @(posedge clk); #1;
      ia.start = 1'b0;
      chk("a_start_while_busy", ia.busy, 1);
      rdy_mode = 1;
      feed(0, 9, HA + 6, 300, n);
      chk("a_toggle_rows", n, HA - 2);
      wait_done(0, 300);
      rdy_mode = 0;
    end

    // Reset mid-block, then a clean block afterwards
    rand_img(255);
    push_model(0, 3, 1);
    do_start(0, 3, 1);
    feed(0, 0, 9, 50, n);
    chk("a_pre_rst_rows", n, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_a();
    sb_a.delete();
    rst = 1'b0;
    rand_img(255);
    push_model(0, 1, 2);
    do_start(0, 1, 2);
    feed(0, 0, HA + 6, 200, n);
    chk("a_post_rst_rows", n, HA + 7);
    wait_done(0, 100);

    // 10-bit, 16 wide, 4 high, phase (1,3)
    rand_img(1023);
    push_model(1, 1, 3);
    do_start(1, 1, 3);
    feed(1, 0, HB + 6, 100, n);
    chk("b_rows", n, HB + 7);
    chk("b_row_idx_sat", ib.row_idx, HB + 6);
    chk("b_in_ready_drain", ib.in_ready, 0);
    wait_done(1, 100);
    chk("b_out_count", outs_b, HB);
    chk("b_sb_empty", sb_b.size(), 0);
    chk("a_sb_empty", sb_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
